// File: rtl/npu_result_drain.sv
// npu_result_drain: pops NPU result words from the FIFO and streams them as LSB-first bytes, one header byte per group of 2N words
// Ports:
//   clk, rst               single clock, synchronous active-high reset
//   fifo_dout, empty       result FIFO read data (valid the cycle after rd_en) and empty flag
//   rd_en                  one-cycle pop strobe per word
//   tx_data, tx_valid      byte stream toward the host link
//   tx_ready               sink accepts tx_data on tx_valid && tx_ready
//   busy                   high whenever not idle
//   group_cnt              completed groups since reset, wraps
module npu_result_drain #(
    parameter int N = 2,
    parameter logic [7:0] HDR = 8'hA5,
    localparam int WIDTH = 15 + N,
    localparam int NB = (WIDTH + 7) / 8,
    localparam int GRP = 2 * N
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] fifo_dout,
    input  logic             empty,
    output logic             rd_en,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic [15:0]      group_cnt
);
    localparam int SW = NB * 8;
    localparam int BW = NB > 1 ? $clog2(NB) : 1;
    localparam int WW = $clog2(GRP);
    typedef enum logic [2:0] {IDLE, HEAD, POP, CAP, SEND} state_t;
    state_t state;
    logic [BW-1:0] byte_idx;
    logic [WW-1:0] word_idx;
    logic [NB-1:0][7:0] sreg;
    // outputs decode only the registered state, never tx_ready or empty
    assign rd_en = state == POP;
    assign tx_valid = state == HEAD || state == SEND;
    assign busy = state != IDLE;
    assign tx_data = state == HEAD ? HDR : state == SEND ? sreg[byte_idx] : 8'h00;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            word_idx <= '0;
            byte_idx <= '0;
            sreg <= '0;
            group_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (!empty) state <= word_idx == '0 ? HEAD : POP;
                HEAD: if (tx_ready) state <= POP;
                POP: state <= CAP;
                CAP: begin
                    sreg <= SW'(fifo_dout);
                    byte_idx <= '0;
                    state <= SEND;
                end
                SEND: if (tx_ready) begin
                    byte_idx <= byte_idx + BW'(1);
                    if (byte_idx == BW'(NB - 1)) begin
                        state <= IDLE;
                        word_idx <= word_idx == WW'(GRP - 1) ? '0 : word_idx + WW'(1);
                        if (word_idx == WW'(GRP - 1)) group_cnt <= group_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_npu_result_drain.sv
// tb_npu_result_drain: table-driven and directed checks of the result drain byte stream
module tb_npu_result_drain;
    logic clk = 0, rst = 1, tx_ready = 1;
    logic [16:0] fifo_dout = '0;
    logic empty, rd_en, tx_valid, busy;
    logic [7:0] tx_data;
    logic [15:0] group_cnt;
    always #5 clk = ~clk;
    npu_result_drain dut (
        .clk(clk), .rst(rst), .fifo_dout(fifo_dout), .empty(empty), .rd_en(rd_en),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .group_cnt(group_cnt)
    );
    logic [16:0] fmem [64];
    int n_push = 0, n_pop = 0;
    assign empty = n_push == n_pop;
    always @(posedge clk) if (rd_en && !empty) begin
        fifo_dout <= fmem[n_pop % 64];
        n_pop <= n_pop + 1;
    end
    logic [7:0] rx [$];
    int rd_cnt = 0, stall_chk = 0, stall_bad = 0;
    logic stall_prev = 0;
    logic [7:0] stall_data = '0;
    always @(negedge clk) begin
        if (rst) stall_prev = 0;
        else begin
            if (stall_prev) begin
                stall_chk++;
                if (!tx_valid || tx_data !== stall_data) begin
                    stall_bad++;
                    $display("FAIL stall_hold act=%0b/%h exp=1/%h", tx_valid, tx_data, stall_data);
                end
            end
            stall_prev = tx_valid && !tx_ready;
            stall_data = tx_data;
            if (tx_valid && tx_ready) rx.push_back(tx_data);
            if (rd_en) rd_cnt++;
        end
    end
    typedef struct packed {
        logic [16:0] w;
        logic [23:0] b;
    } vec_t;
    vec_t tv [8];
    logic [7:0] expq [$];
    logic [3:0] pat = 4'b1001;
    int total = 0, bad = 0, base = 0, rd0 = 0;
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask
    task automatic push(input int i);
        fmem[n_push % 64] = tv[i].w;
        n_push++;
    endtask
    task automatic add_word(input int i);
        for (int j = 0; j < 3; j++) expq.push_back(tv[i].b[23-8*j -: 8]);
    endtask
    task automatic start;
        base = rx.size();
        rd0 = rd_cnt;
        expq.delete();
    endtask
    task automatic wait_rx(input int n, input bit tog);
        int k = 0;
        while (rx.size() - base < n && k < 3000) begin
            tx_ready = tog ? pat[k % 4] : 1'b1;
            tick;
            k++;
        end
        tx_ready = 1;
        if (k >= 3000) chk("timeout", rx.size() - base, n);
    endtask
    task automatic cmp_stream(input string nm);
        chk({nm, "_len"}, rx.size() - base, expq.size());
        for (int i = 0; i < expq.size() && base + i < rx.size(); i++)
            chk($sformatf("%s_b%0d", nm, i), rx[base+i], expq[i]);
    endtask
    initial begin
        tv[0] = '{17'h12345, 24'h452301};
        tv[1] = '{17'h00001, 24'h010000};
        tv[2] = '{17'h1FFFF, 24'hFFFF01};
        tv[3] = '{17'h00000, 24'h000000};
        tv[4] = '{17'h10000, 24'h000001};
        tv[5] = '{17'h0ABCD, 24'hCDAB00};
        tv[6] = '{17'h1A5A5, 24'hA5A501};
        tv[7] = '{17'h00100, 24'h000100};
        tick;
        tick;
        chk("rst_rd_en", rd_en, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_group_cnt", group_cnt, 0);
        rst = 0;
        for (int i = 0; i < 50; i++) begin
            tick;
            chk("idle_outs", {rd_en, tx_valid, busy}, 0);
        end
        chk("idle_group_cnt", group_cnt, 0);
        start;
        for (int i = 0; i < 8; i++) begin
            push(i);
            if (i % 4 == 0) expq.push_back(8'hA5);
            add_word(i);
        end
        wait_rx(26, 0);
        cmp_stream("table");
        chk("table_group_cnt", group_cnt, 2);
        chk("table_rd_pulses", rd_cnt - rd0, 8);
        start;
        expq.push_back(8'hA5);
        for (int i = 0; i < 4; i++) begin
            push(i);
            add_word(i);
        end
        wait_rx(13, 1);
        cmp_stream("bp");
        chk("bp_group_cnt", group_cnt, 3);
        chk("bp_rd_pulses", rd_cnt - rd0, 4);
        chk("bp_stall_bad", stall_bad, 0);
        chk("bp_stalls_seen", stall_chk > 0, 1);
        start;
        expq.push_back(8'hA5);
        for (int i = 0; i < 4; i++) add_word(i);
        push(0);
        push(1);
        tick;
        chk("head_latency", {tx_valid, tx_data}, {1'b1, 8'hA5});
        wait_rx(7, 0);
        chk("gap_group_cnt", group_cnt, 3);
        repeat (20) tick;
        chk("gap_quiet_bytes", rx.size() - base, 7);
        chk("gap_busy", busy, 0);
        push(2);
        push(3);
        tick;
        chk("mid_pop", {rd_en, tx_valid}, 2'b10);
        tick;
        chk("mid_cap", {rd_en, tx_valid, busy}, 3'b001);
        tick;
        chk("mid_first_byte", {tx_valid, tx_data}, {1'b1, 8'hFF});
        wait_rx(12, 0);
        chk("gap_cnt_before_last", group_cnt, 3);
        wait_rx(13, 0);
        chk("gap_cnt_after_last", group_cnt, 4);
        cmp_stream("gap");
        start;
        for (int i = 4; i < 8; i++) push(i);
        wait_rx(5, 0);
        rst = 1;
        tick;
        chk("mid_rst_outs", {rd_en, tx_valid, busy}, 0);
        chk("mid_rst_tx_data", tx_data, 0);
        chk("mid_rst_group_cnt", group_cnt, 0);
        rst = 0;
        start;
        expq.push_back(8'hA5);
        add_word(6);
        add_word(7);
        add_word(0);
        add_word(1);
        wait_rx(7, 0);
        chk("after_rst_group_cnt", group_cnt, 0);
        push(0);
        push(1);
        wait_rx(13, 0);
        cmp_stream("after_rst");
        chk("after_rst_group_done", group_cnt, 1);
        force dut.group_cnt = 16'hFFFF;
        tick;
        release dut.group_cnt;
        tick;
        chk("wrap_preset", group_cnt, 16'hFFFF);
        start;
        for (int i = 0; i < 4; i++) push(i);
        wait_rx(13, 0);
        chk("wrap_group_cnt", group_cnt, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
